mousetrap_sync_sink: RTL

- Clocked consumer placed directly downstream of the last MouseTrap latch stage.
- Accepts 2-phase (transition-signalled) bundled-data tokens (InReq/InData) and returns a 2-phase InAck.
- Synchronises the request into the Clk domain and buffers tokens in a small show-ahead FIFO.
- Presents tokens as a valid/ready stream to synchronous logic; the async pipeline is back-pressured by withholding InAck.

---
 rtl/mousetrap_sync_sink.sv | 108 ++++++++++
 1 files changed

// File: rtl/mousetrap_sync_sink.sv
// Clocked sink for a 2-phase MouseTrap pipeline: synchronises InReq, buffers
// bundled tokens in a show-ahead FIFO and returns InAck once a token is stored.
`timescale 1ns/1ps

module mousetrap_sync_sink #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          Clk,
    input  logic                          extResetN,
    input  logic                          InReq,
    input  logic [DATA_WIDTH-1:0]         InData,
    output logic                          InAck,
    output logic                          OutValid,
    input  logic                          OutReady,
    output logic [DATA_WIDTH-1:0]         OutData,
    output logic [$clog2(FIFO_DEPTH):0]   Count,
    output logic                          Stalled,
    output logic                          dbg_state
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    req_sync;
    logic                    ack_q;
    logic                    pending;
    logic                    pop;
    logic                    can_write;
    logic                    wr_en;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           count_q;
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];

    // Output stream: a token moves on every edge where OutValid and OutReady
    // are both high; OutData is the head entry and is only meaningful while
    // OutValid is high. Upstream side is 2-phase: a token is outstanding
    // while the synchronised InReq differs from InAck.
    assign req_sync  = sync_q[SYNC_STAGES-1];
    assign pending   = req_sync ^ ack_q;
    assign pop       = OutValid & OutReady;
    assign can_write = (count_q < CW'(FIFO_DEPTH)) | pop;

    assign InAck     = ack_q;
    assign OutValid  = (count_q != '0);
    assign OutData   = mem[rd_ptr];
    assign Count     = count_q;
    assign Stalled   = (state_q == STALL);
    assign dbg_state = state_q;

    always_comb begin
        state_d = IDLE;
        wr_en   = 1'b0;
        if (pending) begin
            if (can_write) begin
                wr_en = 1'b1;
            end else begin
                state_d = STALL;
            end
        end
    end

    always_ff @(posedge Clk or negedge extResetN) begin
        if (!extResetN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // InAck comes straight from ack_q so it never glitches with InReq.
    always_ff @(posedge Clk or negedge extResetN) begin
        if (!extResetN) begin
            sync_q  <= '0;
            ack_q   <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], InReq};
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                ack_q  <= ~ack_q;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_q + CW'(wr_en) - CW'(pop);
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= InData;
        end
    end

endmodule
